// File: rtl/main_alu_decoder_if.sv
// Decoder bus: opcode/zero in, registered control strobes out.
// Master drives op/zero; the decoder is the slave.
interface main_alu_decoder_if;
    logic [3:0] op;
    logic       zero;
    logic       memtoreg;
    logic       memwrite;
    logic       pcsrc;
    logic       alusrc;
    logic       regdst;
    logic       regwrite;
    logic       jump;
    logic [1:0] aluop;
    logic [3:0] alucontrol;

    modport master (
        output op, zero,
        input  memtoreg, memwrite, pcsrc, alusrc,
        input  regdst, regwrite, jump, aluop, alucontrol
    );

    modport slave (
        input  op, zero,
        output memtoreg, memwrite, pcsrc, alusrc,
        output regdst, regwrite, jump, aluop, alucontrol
    );
endinterface

// File: rtl/main_alu_decoder.sv
// Main + ALU control decoder with a single registered output stage.
// Decode is combinational from op/zero; outputs appear one clk later.
module main_alu_decoder (
    input  logic               clk,
    input  logic               reset,
    main_alu_decoder_if.slave  bus
);

    typedef struct packed {
        logic       memtoreg;
        logic       memwrite;
        logic       pcsrc;
        logic       alusrc;
        logic       regdst;
        logic       regwrite;
        logic       jump;
        logic [1:0] aluop;
        logic [3:0] alucontrol;
    } ctrl_t;

    ctrl_t d;
    ctrl_t q;

    always_comb begin
        d = '0;
        unique case (bus.op)
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0100, 4'b0101, 4'b0110, 4'b0111: begin
                d.regdst   = 1'b1;
                d.regwrite = 1'b1;
                d.aluop    = 2'b10;
            end
            4'b1000: begin
                d.alusrc   = 1'b1;
                d.regwrite = 1'b1;
            end
            4'b1001: begin
                d.alusrc   = 1'b1;
                d.regwrite = 1'b1;
                d.memtoreg = 1'b1;
            end
            4'b1010: begin
                d.alusrc   = 1'b1;
                d.memwrite = 1'b1;
            end
            4'b1011: begin
                d.pcsrc = bus.zero;
                d.aluop = 2'b01;
            end
            4'b1100: begin
                d.pcsrc = ~bus.zero;
                d.aluop = 2'b01;
            end
            4'b1101: d.jump  = 1'b1;
            4'b1110: begin
                d.alusrc   = 1'b1;
                d.regwrite = 1'b1;
                d.aluop    = 2'b11;
            end
            default: d = '0;
        endcase

        unique case (1'b1)
            (d.aluop == 2'b00): d.alucontrol = 4'b0010;
            (d.aluop == 2'b01): d.alucontrol = 4'b0110;
            (d.aluop == 2'b11): d.alucontrol = 4'b0000;
            (d.aluop == 2'b10): begin
                case (bus.op)
                    4'b0000: d.alucontrol = 4'b0010;
                    4'b0001: d.alucontrol = 4'b0110;
                    4'b0010: d.alucontrol = 4'b0000;
                    4'b0011: d.alucontrol = 4'b0001;
                    4'b0100: d.alucontrol = 4'b0011;
                    4'b0101: d.alucontrol = 4'b0111;
                    4'b0110: d.alucontrol = 4'b1000;
                    4'b0111: d.alucontrol = 4'b1001;
                    default: d.alucontrol = 4'b0000;
                endcase
            end
            default: d.alucontrol = 4'b0000;
        endcase

        // NOP and unknown opcodes leave the whole bundle quiet
        if (bus.op == 4'b1111 || $isunknown(bus.op)) begin
            d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

    assign bus.memtoreg   = q.memtoreg;
    assign bus.memwrite   = q.memwrite;
    assign bus.pcsrc      = q.pcsrc;
    assign bus.alusrc     = q.alusrc;
    assign bus.regdst     = q.regdst;
    assign bus.regwrite   = q.regwrite;
    assign bus.jump       = q.jump;
    assign bus.aluop      = q.aluop;
    assign bus.alucontrol = q.alucontrol;

endmodule

// File: tb/tb_main_alu_decoder.sv
// Scoreboard bench: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares each registered result.
module tb_main_alu_decoder;

    logic clk;
    logic reset;
    main_alu_decoder_if bus ();

    main_alu_decoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  op;
        logic        zero;
        logic [12:0] e;
    } item_t;

    item_t q[$];
    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {memtoreg,memwrite,pcsrc,alusrc,regdst,regwrite,jump,aluop,alucontrol}
    function automatic logic [12:0] act();
        return {bus.memtoreg, bus.memwrite, bus.pcsrc, bus.alusrc,
                bus.regdst, bus.regwrite, bus.jump,
                bus.aluop, bus.alucontrol};
    endfunction

    always @(negedge clk) begin
        if (q.size() > 0) begin
            item_t it;
            logic [12:0] a;
            it = q.pop_front();
            a = act();
            checks++;
            if (a !== it.e) begin
                errors++;
                $display("FAIL dec op=%b z=%b got=%b want=%b",
                         it.op, it.zero, a, it.e);
            end
            checks++;
            if ((a[11] & a[7]) | (a[10] & a[6])) begin
                errors++;
                $display("FAIL excl op=%b got=%b want no overlap",
                         it.op, a);
            end
        end
    end

    task automatic step(input logic [3:0] o, input logic z,
                        input logic [12:0] e);
        item_t it;
        @(negedge clk);
        #1;
        bus.op   = o;
        bus.zero = z;
        it.op = o;
        it.zero = z;
        it.e = e;
        q.push_back(it);
    endtask

    task automatic chk0(input string nm);
        logic [12:0] a;
        a = act();
        checks++;
        if (a !== 13'd0) begin
            errors++;
            $display("FAIL %s got=%b want=0", nm, a);
        end
    endtask

    initial begin
        item_t it;
        int waitc;
        reset = 1'b0;
        bus.op = 4'b1001;
        bus.zero = 1'b0;
        #3;
        chk0("rst_async");
        repeat (2) @(posedge clk);
        #1;
        chk0("rst_hold");

        @(negedge clk);
        #1;
        reset = 1'b1;
        it.op = 4'b1001;
        it.zero = 1'b0;
        it.e = {7'b1001010, 2'b00, 4'b0010};
        q.push_back(it);

        step(4'b0101, 0, {7'b0000110, 2'b10, 4'b0111});
        step(4'b0000, 0, {7'b0000110, 2'b10, 4'b0010});
        step(4'b0001, 0, {7'b0000110, 2'b10, 4'b0110});
        step(4'b0010, 0, {7'b0000110, 2'b10, 4'b0000});
        step(4'b0011, 0, {7'b0000110, 2'b10, 4'b0001});
        step(4'b0100, 0, {7'b0000110, 2'b10, 4'b0011});
        step(4'b0101, 1, {7'b0000110, 2'b10, 4'b0111});
        step(4'b0110, 0, {7'b0000110, 2'b10, 4'b1000});
        step(4'b0111, 0, {7'b0000110, 2'b10, 4'b1001});
        step(4'b1000, 0, {7'b0001010, 2'b00, 4'b0010});
        step(4'b1011, 1, {7'b0010000, 2'b01, 4'b0110});
        step(4'b1011, 0, {7'b0000000, 2'b01, 4'b0110});
        step(4'b1100, 0, {7'b0010000, 2'b01, 4'b0110});
        step(4'b1100, 1, {7'b0000000, 2'b01, 4'b0110});
        step(4'b1101, 1, {7'b0000001, 2'b00, 4'b0010});
        step(4'b1010, 0, {7'b0101000, 2'b00, 4'b0010});
        step(4'b1110, 0, {7'b0001010, 2'b11, 4'b0000});
        step(4'b1111, 1, {7'b0000000, 2'b00, 4'b0000});
        step(4'b0000, 0, {7'b0000110, 2'b10, 4'b0010});

        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk0("rst_mid");
        bus.op = 4'b1001;
        @(posedge clk);
        #1;
        chk0("rst_discard");

        @(negedge clk);
        #1;
        reset = 1'b1;
        bus.op = 4'b1101;
        it.op = 4'b1101;
        it.zero = 1'b0;
        it.e = {7'b0000001, 2'b00, 4'b0010};
        q.push_back(it);

        step(4'b1111, 0, {7'b0000000, 2'b00, 4'b0000});

        waitc = 0;
        while (q.size() > 0 && waitc < 20) begin
            @(posedge clk);
            waitc++;
        end
        @(negedge clk);
        #1;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got=running want=done");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/main_alu_decoder.md
MAIN_ALU_DECODER -- requirements
Module: main_alu_decoder

Interface
REQ-001 The block SHALL have exactly one clock; reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for the output register stage.
REQ-003 reset  input  1  asynchronous active-low reset; 0 = asserted.
REQ-004 op  input  4  instruction opcode.
REQ-005 zero  input  1  ALU zero flag, used for branch resolution.
REQ-006 memtoreg, memwrite, pcsrc, alusrc, regdst, regwrite, jump  output  1 each  registered control strobes.
REQ-007 aluop  output  2  registered ALU operation class: 00 add, 01 sub, 10 R-type, 11 immediate-logical.
REQ-008 alucontrol  output  4  registered ALU function select.

Function
REQ-009 Decoding SHALL be combinational from op/zero; all outputs SHALL be registered on the rising clk edge, giving 1-cycle latency.
REQ-010 Main decode table, listing only the signals set to 1 (all others 0), with aluop:
- 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLL, 0111 SRL: regdst, regwrite; aluop=10.
- 1000 ADDI: alusrc, regwrite; aluop=00.
- 1001 LW: alusrc, regwrite, memtoreg; aluop=00.
- 1010 SW: alusrc, memwrite; aluop=00.
- 1011 BEQ: pcsrc=zero; aluop=01.
- 1100 BNE: pcsrc=~zero; aluop=01.
- 1101 J: jump; aluop=00.
- 1110 ANDI: alusrc, regwrite; aluop=11.
- 1111 NOP: all strobes 0; aluop=00.
REQ-011 ALU decode SHALL be driven by the decoded aluop:
- aluop 00: alucontrol=0010 (add).
- aluop 01: alucontrol=0110 (subtract).
- aluop 10, by op: 0000 gives 0010, 0001 gives 0110, 0010 gives 0000, 0011 gives 0001, 0100 gives 0011, 0101 gives 0111, 0110 gives 1000, 0111 gives 1001.
- aluop 11: alucontrol=0000 (and).
REQ-012 Any op/aluop combination not listed SHALL yield alucontrol=0000.
REQ-013 pcsrc SHALL be 1 only for BEQ with zero=1 or BNE with zero=0, sampled in the same cycle as op.
REQ-014 memwrite and regwrite SHALL never both be 1.
REQ-015 jump and pcsrc SHALL never both be 1.
REQ-016 X or Z on op SHALL NOT propagate: the default decode branch SHALL produce the NOP encoding.
REQ-017 The block SHALL have no state other than the output register.

Reset
REQ-018 While reset=0, all outputs SHALL be 0 (aluop=00, alucontrol=0000), immediately and independent of clk.
REQ-019 Reset asserted mid-operation SHALL clear outputs at once, discarding any pending decode.
REQ-020 The first rising clk edge after reset deasserts SHALL load the decode of the op present at that edge.

Verification
REQ-021 Scenario: reset=0, op=1001 -> all outputs 0. Release reset, one clk -> alusrc=1, regwrite=1, memtoreg=1, aluop=00, alucontrol=0010.
REQ-022 Scenario: op=0101 -> after one clk, regdst=1, regwrite=1, aluop=10, alucontrol=0111. Step op through 0000..0111 -> alucontrol follows the aluop-10 mapping in REQ-011.
REQ-023 Scenario: op=1011 with zero=1 -> pcsrc=1, alucontrol=0110. Same op with zero=0 -> pcsrc=0.
REQ-024 Scenario: op=1100 with zero=0 -> pcsrc=1. op=1101 -> jump=1, pcsrc=0.
REQ-025 Scenario: op=1010 -> memwrite=1, regwrite=0, alucontrol=0010. op=1110 -> aluop=11, alucontrol=0000, alusrc=1.
REQ-026 Scenario: assert reset=0 between clk edges while op=0000 -> outputs go to 0 before the next edge. op=1111 -> all outputs 0.
